// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: program-memory read port, IR load, decoder length,
// execute handshake, redirect and halt signalling.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              enable;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [7:0]        mem_data;
  logic              ir_load;
  logic [7:0]        ir_data;
  logic [1:0]        len_code;
  logic [7:0]        operand_lo;
  logic [7:0]        operand_hi;
  logic              instr_valid;
  logic              instr_accept;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_new;
  logic              halt_req;
  logic              halted;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  enable, mem_ready, mem_data, len_code, instr_accept, pc_load, pc_new, halt_req,
    output mem_addr, mem_rd, ir_load, ir_data, operand_lo, operand_hi, instr_valid, halted, pc
  );

  modport slave (
    output enable, mem_ready, mem_data, len_code, instr_accept, pc_load, pc_new, halt_req,
    input  mem_addr, mem_rd, ir_load, ir_data, operand_lo, operand_hi, instr_valid, halted, pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads opcode plus 0-2 operand bytes
// from program memory and hands the instruction to execute.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_unit_if.master   bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_B2   = 3'd3;
  localparam logic [2:0] S_B3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]        lo_q, lo_d, hi_q, hi_d;
  logic [1:0]        len_q, len_d;
  logic              kill_q;
  logic              mem_rd, ir_load, instr_valid, halted;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    len_d       = len_q;
    mem_rd      = 1'b0;
    ir_load     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_IDLE: if (bus.enable) state_d = S_OP;
      // kill_q gives one idle cycle after a redirect so a late ready from
      // the abandoned read is never mistaken for the new opcode.
      S_OP: if (!kill_q) begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_load = 1'b1;
          pc_d    = pc_inc;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        len_d   = bus.len_code;
        state_d = bus.len_code[1] ? S_B2 : S_DONE;
      end
      S_B2: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          lo_d    = bus.mem_data;
          pc_d    = pc_inc;
          state_d = (len_q == 2'd3) ? S_B3 : S_DONE;
        end
      end
      S_B3: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          hi_d    = bus.mem_data;
          pc_d    = pc_inc;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        instr_valid = 1'b1;
        if (bus.instr_accept) state_d = bus.halt_req ? S_HALT : S_OP;
      end
      S_HALT:  halted  = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // Redirect overrides everything: data arriving this cycle is dropped.
    if (bus.pc_load) begin
      pc_d    = bus.pc_new;
      state_d = S_OP;
      lo_d    = lo_q;
      hi_d    = hi_q;
      ir_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      lo_q    <= '0;
      hi_q    <= '0;
      len_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      kill_q  <= bus.pc_load;
    end
  end

  assign bus.mem_rd      = mem_rd;
  assign bus.mem_addr    = pc_q;
  assign bus.ir_load     = ir_load;
  assign bus.ir_data     = bus.mem_data;
  assign bus.operand_lo  = lo_q;
  assign bus.operand_hi  = hi_q;
  assign bus.instr_valid = instr_valid;
  assign bus.halted      = halted;
  assign bus.pc          = pc_q;
endmodule
